accel_frame_seq: RTL and testbench
==================================

# accel_frame_seq

Frame sequencer for the pixel accelerator at 0x0400_0000. It gates the processor's input acceptance so that exactly one programmed frame of pixels enters the datapath. It counts the accepted inputs and the produced results, waits for the datapath to drain, then reports done, timeout, abort or overflow through sticky status bits and a level interrupt. It sits on the iomem bus as a small register slave beside the accelerator config window.

## Interface
- `CNT_WIDTH`, 16: width of the length registers and counters.
- `DRAIN_TIMEOUT`, 255: number of consecutive cycles without `out_fire` in DRAIN before the frame is abandoned.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `reg_valid`  in  1  bus request, already address-decoded for this block.
- `reg_wstrb`  in  4  byte strobes; 0 means read.
- `reg_addr`  in  8  byte offset.
- `reg_wdata`  in  32  write data.
- `reg_ready`  out  1  equals `reg_valid` (combinational, single-cycle).
- `reg_rdata`  out  32  read data (combinational).
- `in_fire`  in  1  one pixel accepted by the processor this cycle.
- `out_fire`  in  1  one result written to the output FIFO this cycle.
- `out_fifo_full`  in  1  output FIFO full.
- `src_en`  out  1  registered; ANDed into the processor `in_valid`/`in_ready` path.
- `irq`  out  1  level interrupt, equal to `irq_en & done`.

## Operation
- Register map (word aligned). Writes take effect only when `reg_wstrb==4'hF`; partial writes are ignored. Unmapped reads return 0.
  - 0x00 CTRL: bit0 start (write-only, reads 0); bit1 abort (write-only, reads 0); bit2 irq_en (R/W).
  - 0x04 IN_LEN: R/W, `CNT_WIDTH` bits.
  - 0x08 OUT_LEN: R/W, `CNT_WIDTH` bits.
  - 0x0C STATUS:
    - bit0 busy (RO).
    - bits 1 to 4 are W1C: bit1 done, bit2 timeout, bit3 aborted, bit4 overflow.
    - bits 9:8 state (RO).
  - 0x10 IN_CNT: RO.
  - 0x14 OUT_CNT: RO.
- State machine, encoded IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - IDLE, start written:
    - Clear IN_CNT, OUT_CNT and the timeout counter.
    - If IN_LEN==0, go to DONE; otherwise go to RUN.
  - RUN:
    - Each `in_fire` increments IN_CNT.
    - When `in_fire` makes IN_CNT reach IN_LEN, go to DRAIN.
  - DRAIN:
    - Go to DONE when OUT_CNT==OUT_LEN.
    - Otherwise go to DONE with timeout set after `DRAIN_TIMEOUT` consecutive cycles without `out_fire`.
  - DONE: set done, go to IDLE on the next cycle.
  - Abort written in RUN or DRAIN: go to IDLE and set aborted; done is not set.
- `out_fire` increments OUT_CNT in RUN and DRAIN only. OUT_CNT saturates at all-ones. The timeout counter resets on DRAIN entry and on every `out_fire`.
- `out_fire` while `out_fifo_full`==1 sets overflow in any state.
- busy = state is RUN or DRAIN. While busy:
  - start is ignored.
  - writes to IN_LEN and OUT_LEN are ignored.
  - irq_en stays writable.
- Simultaneous events:
  - Abort wins over the last `in_fire` and over DRAIN completion.
  - A status set wins over a W1C clear in the same cycle.
  - `in_fire` outside RUN is not counted.

## Timing
- Reset: state IDLE; all registers, counters and flags 0; `src_en`=0; `irq`=0.
- Reset acts immediately, without a clock edge, and aborts any frame in progress with no flags set.
- Start accepted at edge t: state=RUN and `src_en`=1 are visible after t.
- `src_en` = registered (next_state==RUN). It drops in the cycle after the last `in_fire`, so `in_fire` never exceeds IN_LEN provided the gating is applied.
- Completion condition met at edge t: DONE after t, done and `irq` high after t+1, IDLE after t+1.
- IN_LEN=0: done is set 2 edges after the start write.
- Register reads reflect the value before the current edge.

## Test plan
- IN_LEN=8, OUT_LEN=8, irq_en=1, `in_fire` every cycle while `src_en`, `out_fire` 3 cycles after each input -> exactly 8 `in_fire` accepted; IN_CNT=8; OUT_CNT=8; STATUS=0x002; `irq`=1. W1C 0x2 to STATUS -> `irq`=0.
- `DRAIN_TIMEOUT`=4, IN_LEN=4, OUT_LEN=10, only 6 `out_fire` -> DONE 4 cycles after the last `out_fire`; STATUS=0x006; OUT_CNT=6.
- Abort after 3 `in_fire` -> `src_en`=0 next cycle; state IDLE; IN_CNT=3; STATUS=0x008; `irq`=0.
- `out_fire` with `out_fifo_full`=1 in IDLE -> overflow=1. W1C 0x10 on the same cycle as a second overflow event -> overflow remains 1. W1C alone -> overflow=0.
- IN_LEN=0, then start -> `src_en` never 1; done=1. Then start IN_LEN=5, and while busy write IN_LEN=9 and start again -> IN_LEN reads 5; frame ends at IN_CNT=5.
- Assert `reset` mid-DRAIN between clock edges -> `src_en`, `irq` and STATUS read 0 immediately; after release, IN_CNT=0 and state=IDLE.

Source files
------------

// File: rtl/accel_frame_seq.sv
// Frame sequencer: admits exactly IN_LEN pixels into the accelerator, waits for the
// results to drain, and reports completion through sticky status bits and an interrupt.
module accel_frame_seq #(
    parameter int CNT_WIDTH     = 16,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_valid,
    input  logic [3:0]  reg_wstrb,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic        reg_ready,
    output logic [31:0] reg_rdata,
    input  logic        in_fire,
    input  logic        out_fire,
    input  logic        out_fifo_full,
    output logic        src_en,
    output logic        irq
);

    localparam int TMO_W = (DRAIN_TIMEOUT < 2) ? 1 : $clog2(DRAIN_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [CNT_WIDTH-1:0] in_len, out_len, in_cnt, out_cnt, in_cnt_inc;
    logic [TMO_W-1:0]     tmo_cnt;
    logic irq_en, done, timeout, aborted, overflow;
    logic busy, wr_full, wr_ctrl, wr_in_len, wr_out_len, wr_status;
    logic start_req, abort_req, tmo_hit;
    logic set_done, set_timeout, set_aborted, set_overflow, clr_cnt;
    logic unused_wdata;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign reg_ready    = reg_valid;
    assign wr_full      = reg_valid && (reg_wstrb == 4'hF);
    assign wr_ctrl      = wr_full && (reg_addr == 8'h00);
    assign wr_in_len    = wr_full && (reg_addr == 8'h04);
    assign wr_out_len   = wr_full && (reg_addr == 8'h08);
    assign wr_status    = wr_full && (reg_addr == 8'h0C);
    assign start_req    = wr_ctrl && reg_wdata[0];
    assign abort_req    = wr_ctrl && reg_wdata[1];
    assign busy         = (state == RUN) || (state == DRAIN);
    assign in_cnt_inc   = in_cnt + CNT_ONE;
    assign tmo_hit      = (tmo_cnt == TMO_W'(DRAIN_TIMEOUT - 1));
    assign set_overflow = out_fire && out_fifo_full;
    assign irq          = irq_en & done;
    assign unused_wdata = ^reg_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            src_en <= 1'b0;
        end else begin
            state  <= next_state;
            src_en <= (next_state == RUN);
        end
    end

    // Abort outranks both the final input and drain completion.
    always_comb begin
        next_state  = state;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        set_aborted = 1'b0;
        clr_cnt     = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    clr_cnt    = 1'b1;
                    next_state = (in_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_req) begin
                    next_state  = IDLE;
                    set_aborted = 1'b1;
                end else if (in_fire && (in_cnt_inc == in_len)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_req) begin
                    next_state  = IDLE;
                    set_aborted = 1'b1;
                end else if (out_cnt == out_len) begin
                    next_state = DONE;
                end else if (!out_fire && tmo_hit) begin
                    next_state  = DONE;
                    set_timeout = 1'b1;
                end
            end
            DONE: begin
                set_done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            tmo_cnt <= '0;
        end else if (clr_cnt) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if ((state == RUN) && in_fire)
                in_cnt <= in_cnt_inc;
            if (busy && out_fire)
                out_cnt <= sat_inc(out_cnt);
            // Held at zero outside DRAIN, so it is already cleared on DRAIN entry.
            if ((state != DRAIN) || out_fire)
                tmo_cnt <= '0;
            else if (!tmo_hit)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en  <= 1'b0;
            in_len  <= '0;
            out_len <= '0;
        end else begin
            if (wr_ctrl)
                irq_en <= reg_wdata[2];
            if (wr_in_len && !busy)
                in_len <= reg_wdata[CNT_WIDTH-1:0];
            if (wr_out_len && !busy)
                out_len <= reg_wdata[CNT_WIDTH-1:0];
        end
    end

    // Sticky flags: a set in the same cycle beats a write-one-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            timeout  <= 1'b0;
            aborted  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (set_done)
                done <= 1'b1;
            else if (wr_status && reg_wdata[1])
                done <= 1'b0;
            if (set_timeout)
                timeout <= 1'b1;
            else if (wr_status && reg_wdata[2])
                timeout <= 1'b0;
            if (set_aborted)
                aborted <= 1'b1;
            else if (wr_status && reg_wdata[3])
                aborted <= 1'b0;
            if (set_overflow)
                overflow <= 1'b1;
            else if (wr_status && reg_wdata[4])
                overflow <= 1'b0;
        end
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            8'h00: reg_rdata = {29'd0, irq_en, 2'b00};
            8'h04: reg_rdata = 32'(in_len);
            8'h08: reg_rdata = 32'(out_len);
            8'h0C: reg_rdata = {22'd0, 2'(state), 3'd0, overflow, aborted, timeout, done, busy};
            8'h10: reg_rdata = 32'(in_cnt);
            8'h14: reg_rdata = 32'(out_cnt);
            default: reg_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_accel_frame_seq.sv
// Directed bench for accel_frame_seq: register-map table plus hand-written frame sequences.
module tb_accel_frame_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_valid = 1'b0;
    logic [3:0]  reg_wstrb = 4'h0;
    logic [7:0]  reg_addr = 8'h00;
    logic [31:0] reg_wdata = 32'd0;
    logic        reg_ready;
    logic [31:0] reg_rdata;
    logic        in_fire, out_fire;
    logic        out_fifo_full = 1'b0;
    logic        src_en, irq;

    logic        in_req = 1'b0;
    logic        out_auto = 1'b0;
    logic        out_man = 1'b0;
    logic [2:0]  pipe = 3'b000;
    int          acc = 0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [7:0] A_CTRL = 8'h00, A_INLEN = 8'h04, A_OUTLEN = 8'h08,
                           A_STAT = 8'h0C, A_INCNT = 8'h10, A_OUTCNT = 8'h14;

    always #5 clk = ~clk;

    // Processor model: gated input acceptance, results emerge three cycles later.
    assign in_fire  = in_req & src_en;
    assign out_fire = (pipe[2] & out_auto) | out_man;

    always @(posedge clk) begin
        pipe <= {pipe[1:0], in_fire};
        if (in_fire) acc <= acc + 1;
    end

    accel_frame_seq #(.CNT_WIDTH(16), .DRAIN_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .reg_valid(reg_valid), .reg_wstrb(reg_wstrb), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_ready(reg_ready), .reg_rdata(reg_rdata),
        .in_fire(in_fire), .out_fire(out_fire), .out_fifo_full(out_fifo_full),
        .src_en(src_en), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] d);
        reg_addr  = a;
        reg_wstrb = 4'h0;
        reg_valid = 1'b1;
        #1;
        d = reg_rdata;
        reg_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        peek(a, d);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        reg_valid = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        reg_wstrb = s;
        @(negedge clk);
        reg_valid = 1'b0;
        reg_wstrb = 4'h0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [3:0]  strb;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [31:0] d;
        int base, k;
        bit seen;

        vecs[0]  = '{0, 4'h0, A_CTRL,   32'h0,         32'h0,      "rst_ctrl"};
        vecs[1]  = '{0, 4'h0, A_INLEN,  32'h0,         32'h0,      "rst_inlen"};
        vecs[2]  = '{0, 4'h0, A_OUTLEN, 32'h0,         32'h0,      "rst_outlen"};
        vecs[3]  = '{0, 4'h0, A_STAT,   32'h0,         32'h0,      "rst_status"};
        vecs[4]  = '{0, 4'h0, A_INCNT,  32'h0,         32'h0,      "rst_incnt"};
        vecs[5]  = '{0, 4'h0, A_OUTCNT, 32'h0,         32'h0,      "rst_outcnt"};
        vecs[6]  = '{1, 4'hF, A_INLEN,  32'h0000_1234, 32'h0,      ""};
        vecs[7]  = '{0, 4'h0, A_INLEN,  32'h0,         32'h1234,   "inlen_rw"};
        vecs[8]  = '{1, 4'h3, A_INLEN,  32'h0000_ABCD, 32'h0,      ""};
        vecs[9]  = '{0, 4'h0, A_INLEN,  32'h0,         32'h1234,   "inlen_partial"};
        vecs[10] = '{1, 4'hF, A_OUTLEN, 32'hFFFF_0077, 32'h0,      ""};
        vecs[11] = '{0, 4'h0, A_OUTLEN, 32'h0,         32'h0077,   "outlen_trunc"};
        vecs[12] = '{1, 4'hF, A_CTRL,   32'h0000_0004, 32'h0,      ""};
        vecs[13] = '{0, 4'h0, A_CTRL,   32'h0,         32'h4,      "ctrl_irqen"};
        vecs[14] = '{0, 4'h0, 8'h18,    32'h0,         32'h0,      "unmapped_18"};
        vecs[15] = '{1, 4'h1, A_CTRL,   32'h0000_0001, 32'h0,      ""};
        vecs[16] = '{0, 4'h0, A_STAT,   32'h0,         32'h0,      "partial_start"};
        vecs[17] = '{1, 4'hF, A_CTRL,   32'h0000_0000, 32'h0,      ""};

        // Reset state and register map
        repeat (2) @(negedge clk);
        chk("rst_src_en", {31'd0, src_en}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        reg_valid = 1'b1;
        #1 chk("ready_hi", {31'd0, reg_ready}, 32'd1);
        reg_valid = 1'b0;
        #1 chk("ready_lo", {31'd0, reg_ready}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                rd(vecs[i].addr, d);
                chk(vecs[i].name, d, vecs[i].exp);
            end
        end

        // Full frame with interrupt
        wr(A_INLEN, 32'd8, 4'hF);
        wr(A_OUTLEN, 32'd8, 4'hF);
        wr(A_CTRL, 32'h4, 4'hF);
        in_req = 1'b1;
        out_auto = 1'b1;
        base = acc;
        wr(A_CTRL, 32'h5, 4'hF);
        chk("t1_src_en_after_start", {31'd0, src_en}, 32'd1);
        rd(A_STAT, d);
        chk("t1_status_run", d, 32'h101);
        for (int i = 0; i < 60 && !irq; i++) @(negedge clk);
        chk("t1_irq", {31'd0, irq}, 32'd1);
        chk("t1_accepted", acc - base, 32'd8);
        rd(A_INCNT, d);  chk("t1_incnt", d, 32'd8);
        rd(A_OUTCNT, d); chk("t1_outcnt", d, 32'd8);
        rd(A_STAT, d);   chk("t1_status", d, 32'h002);
        wr(A_STAT, 32'h2, 4'hF);
        chk("t1_irq_clr", {31'd0, irq}, 32'd0);
        in_req = 1'b0;
        out_auto = 1'b0;

        // Drain timeout: 6 of 10 results arrive
        wr(A_INLEN, 32'd4, 4'hF);
        wr(A_OUTLEN, 32'd10, 4'hF);
        in_req = 1'b1;
        wr(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 20 && src_en; i++) @(negedge clk);
        in_req = 1'b0;
        peek(A_STAT, d);
        chk("t2_in_drain", d, 32'h201);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            out_man = 1'b1;
        end
        @(negedge clk);
        out_man = 1'b0;
        k = 0;
        peek(A_STAT, d);
        while (d[9:8] == 2'd2 && k < 20) begin
            @(negedge clk);
            k++;
            peek(A_STAT, d);
        end
        chk("t2_cycles_to_done", k, 32'd4);
        chk("t2_state_done", {30'd0, d[9:8]}, 32'd3);
        rd(A_STAT, d);   chk("t2_status", d, 32'h006);
        rd(A_OUTCNT, d); chk("t2_outcnt", d, 32'd6);
        wr(A_STAT, 32'h1E, 4'hF);

        // Abort after three inputs
        wr(A_INLEN, 32'd8, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        in_req = 1'b1;
        repeat (3) @(negedge clk);
        in_req = 1'b0;
        wr(A_CTRL, 32'h6, 4'hF);
        chk("t3_src_en", {31'd0, src_en}, 32'd0);
        rd(A_STAT, d);  chk("t3_status", d, 32'h008);
        rd(A_INCNT, d); chk("t3_incnt", d, 32'd3);
        chk("t3_irq", {31'd0, irq}, 32'd0);
        wr(A_STAT, 32'h8, 4'hF);

        // Overflow in IDLE, set beats W1C
        @(negedge clk);
        out_fifo_full = 1'b1;
        out_man = 1'b1;
        @(negedge clk);
        out_man = 1'b0;
        peek(A_STAT, d);  chk("t4_ovf_set", d, 32'h010);
        peek(A_OUTCNT, d); chk("t4_outcnt_idle", d, 32'd0);
        @(negedge clk);
        reg_valid = 1'b1; reg_addr = A_STAT; reg_wdata = 32'h10; reg_wstrb = 4'hF;
        out_man = 1'b1;
        @(negedge clk);
        reg_valid = 1'b0; reg_wstrb = 4'h0;
        out_man = 1'b0;
        peek(A_STAT, d);  chk("t4_ovf_set_wins", d, 32'h010);
        wr(A_STAT, 32'h10, 4'hF);
        peek(A_STAT, d);  chk("t4_ovf_clr", d, 32'h000);
        out_fifo_full = 1'b0;

        // Zero-length frame, then busy-write protection
        wr(A_INLEN, 32'd0, 4'hF);
        in_req = 1'b1;
        seen = 1'b0;
        wr(A_CTRL, 32'h1, 4'hF);
        seen = seen | src_en;
        peek(A_STAT, d); chk("t5_zero_in_done_state", d, 32'h300);
        @(negedge clk);
        seen = seen | src_en;
        peek(A_STAT, d); chk("t5_zero_done", d, 32'h002);
        repeat (3) begin
            @(negedge clk);
            seen = seen | src_en;
        end
        chk("t5_zero_src_en", {31'd0, seen}, 32'd0);
        wr(A_STAT, 32'h2, 4'hF);
        wr(A_INLEN, 32'd5, 4'hF);
        wr(A_OUTLEN, 32'd5, 4'hF);
        out_auto = 1'b1;
        base = acc;
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_INLEN, 32'd9, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        peek(A_STAT, d);
        for (int i = 0; i < 60 && !d[1]; i++) begin
            @(negedge clk);
            peek(A_STAT, d);
        end
        chk("t5_status", d, 32'h002);
        rd(A_INLEN, d); chk("t5_inlen_kept", d, 32'd5);
        rd(A_INCNT, d); chk("t5_incnt", d, 32'd5);
        chk("t5_accepted", acc - base, 32'd5);
        in_req = 1'b0;
        out_auto = 1'b0;

        // Asynchronous reset mid-DRAIN (done left set so irq is live)
        wr(A_INLEN, 32'd2, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        in_req = 1'b1;
        for (int i = 0; i < 20 && src_en; i++) @(negedge clk);
        in_req = 1'b0;
        peek(A_STAT, d);
        chk("t6_pre_status", d, 32'h203);
        chk("t6_pre_irq", {31'd0, irq}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_src_en", {31'd0, src_en}, 32'd0);
        chk("t6_rst_irq", {31'd0, irq}, 32'd0);
        peek(A_STAT, d); chk("t6_rst_status", d, 32'h000);
        @(negedge clk);
        reset = 1'b0;
        rd(A_INCNT, d); chk("t6_incnt", d, 32'd0);
        rd(A_STAT, d);  chk("t6_status_idle", d, 32'h000);
        rd(A_INLEN, d); chk("t6_inlen", d, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
